// File: rtl/cpu_jmp_cond_unit.sv
// Conditional-jump evaluation unit: latches compare flags, evaluates a 4-bit
// condition code against flags or accelerator ready lines, optionally stalling until true.
module cpu_jmp_cond_unit #(
    parameter int DATA_WIDTH    = 16,
    parameter int ACCEL_COUNT   = 2,
    parameter int TIMEOUT_WIDTH = 8,
    localparam int SEL_WIDTH    = (ACCEL_COUNT > 1) ? $clog2(ACCEL_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    cmp_a,
    input  logic [DATA_WIDTH-1:0]    cmp_b,
    input  logic                     cmp_signed,
    input  logic                     cmp_we,
    input  logic [3:0]               cond,
    input  logic [SEL_WIDTH-1:0]     accel_sel,
    input  logic [ACCEL_COUNT-1:0]   accel_can_read,
    input  logic [ACCEL_COUNT-1:0]   accel_can_write,
    input  logic                     req,
    input  logic                     wait_mode,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    input  logic                     cancel,
    output logic [2:0]               flags,
    output logic                     busy,
    output logic                     done,
    output logic                     taken,
    output logic                     timed_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                   state_reg, state_next;
    logic [3:0]               cond_reg, cond_next;
    logic [SEL_WIDTH-1:0]     sel_reg, sel_next;
    logic [TIMEOUT_WIDTH-1:0] count_reg, count_next;
    logic [2:0]               flags_reg, flags_next;
    logic                     done_reg, done_next;
    logic                     taken_reg, taken_next;
    logic                     timed_out_reg, timed_out_next;

    // In IDLE the live request fields are evaluated; in WAIT the latched ones.
    logic [3:0]               eval_code;
    logic [SEL_WIDTH-1:0]     eval_sel;
    logic [ACCEL_COUNT-1:0]   sel_hit;
    logic                     rd, wr, result;
    logic                     cmp_eq, cmp_lt;

    assign eval_code = (state_reg == IDLE) ? cond : cond_reg;
    assign eval_sel  = (state_reg == IDLE) ? accel_sel : sel_reg;

    // One-hot channel match; an out-of-range select matches nothing so rd=wr=0.
    generate
        for (genvar gi = 0; gi < ACCEL_COUNT; gi++) begin : g_sel
            assign sel_hit[gi] = (eval_sel == SEL_WIDTH'(gi));
        end
    endgenerate

    assign rd = |(sel_hit & accel_can_read);
    assign wr = |(sel_hit & accel_can_write);

    function automatic logic eval_cond(input logic [3:0] code, input logic [2:0] f,
                                       input logic r, input logic w);
        logic lt, gt, eq;
        lt = f[2];
        gt = f[1];
        eq = f[0];
        case (code)
            4'd0:    return eq;
            4'd1:    return !eq;
            4'd2:    return lt;
            4'd3:    return lt | eq;
            4'd4:    return gt;
            4'd5:    return gt | eq;
            4'd6:    return r;
            4'd7:    return w;
            4'd8:    return !r;
            4'd9:    return !w;
            4'd10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign result = eval_cond(eval_code, flags_reg, rd, wr);

    assign cmp_eq = (cmp_a == cmp_b);
    assign cmp_lt = cmp_signed ? ($signed(cmp_a) < $signed(cmp_b)) : (cmp_a < cmp_b);

    always_comb begin
        flags_next = flags_reg;
        if (cmp_we) begin
            flags_next = {cmp_lt, !cmp_lt && !cmp_eq, cmp_eq};
        end
    end

    always_comb begin
        state_next     = state_reg;
        cond_next      = cond_reg;
        sel_next       = sel_reg;
        count_next     = count_reg;
        done_next      = 1'b0;
        taken_next     = taken_reg;
        timed_out_next = timed_out_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    cond_next  = cond;
                    sel_next   = accel_sel;
                    count_next = timeout;
                    if (!wait_mode || result) begin
                        done_next      = 1'b1;
                        taken_next     = result;
                        timed_out_next = 1'b0;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (result) begin
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    taken_next     = 1'b1;
                    timed_out_next = 1'b0;
                end else if (count_reg == TIMEOUT_WIDTH'(1)) begin
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    taken_next     = 1'b0;
                    timed_out_next = 1'b1;
                end else if (count_reg != '0) begin
                    // Zero means unlimited, so it is never decremented.
                    count_next = count_reg - TIMEOUT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cond_reg      <= '0;
            sel_reg       <= '0;
            count_reg     <= '0;
            flags_reg     <= '0;
            done_reg      <= 1'b0;
            taken_reg     <= 1'b0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cond_reg      <= cond_next;
            sel_reg       <= sel_next;
            count_reg     <= count_next;
            flags_reg     <= flags_next;
            done_reg      <= done_next;
            taken_reg     <= taken_next;
            timed_out_reg <= timed_out_next;
        end
    end

    assign flags     = flags_reg;
    assign busy      = (state_reg == WAIT);
    assign done      = done_reg;
    assign taken     = taken_reg;
    assign timed_out = timed_out_reg;

endmodule

// File: tb/tb_cpu_jmp_cond_unit.sv
// Directed bench for cpu_jmp_cond_unit: a two-channel instance for the main checks and a
// three-channel instance so that an out-of-range accelerator select can be driven.
module tb_cpu_jmp_cond_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmp_a = '0, cmp_b = '0;
    logic        cmp_signed = 1'b0, cmp_we = 1'b0;
    logic [3:0]  cond = '0;
    logic        req = 1'b0, wait_mode = 1'b0, cancel = 1'b0;
    logic [7:0]  timeout = '0;

    logic        accel_sel = 1'b0;
    logic [1:0]  can_read = '0, can_write = '0;
    logic [2:0]  flags;
    logic        busy, done, taken, timed_out;

    logic [1:0]  sel3 = '0;
    logic [2:0]  can_read3 = '0, can_write3 = '0;
    logic [2:0]  flags3;
    logic        busy3, done3, taken3, timed_out3;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    cpu_jmp_cond_unit #(.DATA_WIDTH(16), .ACCEL_COUNT(2), .TIMEOUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_signed(cmp_signed),
        .cmp_we(cmp_we), .cond(cond), .accel_sel(accel_sel), .accel_can_read(can_read),
        .accel_can_write(can_write), .req(req), .wait_mode(wait_mode), .timeout(timeout),
        .cancel(cancel), .flags(flags), .busy(busy), .done(done), .taken(taken),
        .timed_out(timed_out)
    );

    cpu_jmp_cond_unit #(.DATA_WIDTH(16), .ACCEL_COUNT(3), .TIMEOUT_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_signed(cmp_signed),
        .cmp_we(cmp_we), .cond(cond), .accel_sel(sel3), .accel_can_read(can_read3),
        .accel_can_write(can_write3), .req(req), .wait_mode(wait_mode), .timeout(timeout),
        .cancel(cancel), .flags(flags3), .busy(busy3), .done(done3), .taken(taken3),
        .timed_out(timed_out3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic b, input logic d,
                             input logic t, input logic to);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".taken"}, 32'(taken), 32'(t));
        check({tag, ".timed_out"}, 32'(timed_out), 32'(to));
    endtask

    initial begin
        int codes [6];
        int exps  [6];
        codes = '{2, 3, 4, 5, 9, 11};
        exps  = '{0, 0, 1, 1, 1, 0};

        // Reset state
        tick(); tick();
        check("reset.flags", 32'(flags), 32'h0);
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Signed vs unsigned compare of FFFF against 1
        cmp_a = 16'hFFFF; cmp_b = 16'd1; cmp_signed = 1'b1; cmp_we = 1'b1;
        tick();
        check("flags_signed", 32'(flags), 32'b100);
        cmp_signed = 1'b0;
        tick();
        check("flags_unsigned", 32'(flags), 32'b010);
        cmp_a = 16'd5; cmp_b = 16'd5;
        tick();
        check("flags_eq", 32'(flags), 32'b001);
        cmp_we = 1'b0;

        // NE with eq set, no wait: done next cycle, not taken, never busy
        req = 1'b1; cond = 4'd1; wait_mode = 1'b0;
        tick();
        check_out("ne_nowait", 1'b0, 1'b1, 1'b0, 1'b0);
        req = 1'b0;
        tick();
        check_out("ne_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // EQ uses the old flags even though cmp_we changes them on the same edge
        req = 1'b1; cond = 4'd0; cmp_a = 16'd1; cmp_b = 16'd2; cmp_we = 1'b1;
        tick();
        check_out("eq_old_flags", 1'b0, 1'b1, 1'b1, 1'b0);
        check("flags_lt", 32'(flags), 32'b100);
        req = 1'b0; cmp_we = 1'b0;
        tick();
        check_out("taken_hold", 1'b0, 1'b0, 1'b1, 1'b0);

        // CR on channel 1, unlimited wait; ready arrives in cycle N+5
        accel_sel = 1'b1; can_read = 2'b00; cond = 4'd6; wait_mode = 1'b1;
        timeout = 8'd0; req = 1'b1;
        tick();
        check_out("cr_wait_n1", 1'b1, 1'b0, 1'b1, 1'b0);
        req = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            if (i == 3) begin
                req = 1'b1; cond = 4'd10; wait_mode = 1'b0;
            end
            tick();
            check($sformatf("cr_wait_busy_n%0d", i), 32'({busy, done}), 32'b10);
        end
        req = 1'b0;
        tick();
        check("cr_wait_busy_n5", 32'({busy, done}), 32'b10);
        can_read = 2'b10;
        tick();
        check_out("cr_done_n6", 1'b0, 1'b1, 1'b1, 1'b0);
        can_read = 2'b00;

        // LT with gt flags, timeout 3: expires in cycle N+4
        cmp_a = 16'd3; cmp_b = 16'd2; cmp_we = 1'b1;
        tick();
        check("flags_gt", 32'(flags), 32'b010);
        cmp_we = 1'b0;
        cond = 4'd2; wait_mode = 1'b1; timeout = 8'd3; req = 1'b1;
        tick();
        check_out("lt_to_n1", 1'b1, 1'b0, 1'b1, 1'b0);
        req = 1'b0;
        tick();
        check_out("lt_to_n2", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("lt_to_n3", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("lt_to_n4", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_out("lt_to_hold", 1'b0, 1'b0, 1'b0, 1'b1);

        // Never-true code 12 with timeout 1 expires on the first wait edge
        cond = 4'd12; timeout = 8'd1; req = 1'b1;
        tick();
        check_out("c12_to1_n1", 1'b1, 1'b0, 1'b0, 1'b1);
        req = 1'b0;
        tick();
        check_out("c12_to1_n2", 1'b0, 1'b1, 1'b0, 1'b1);

        // Cancel of an unlimited wait: idle from N+3, no done
        cond = 4'd12; timeout = 8'd0; req = 1'b1;
        tick();
        check("cancel_busy_n1", 32'(busy), 32'd1);
        req = 1'b0;
        tick();
        check("cancel_busy_n2", 32'(busy), 32'd1);
        cancel = 1'b1;
        tick();
        check_out("cancel_n3", 1'b0, 1'b0, 1'b0, 1'b1);
        cancel = 1'b0;
        tick();
        check_out("cancel_n4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-wait clears everything without a clock edge
        req = 1'b1;
        tick();
        check("rst_pre_busy", 32'(busy), 32'd1);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async.flags", 32'(flags), 32'h0);
        check_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_out("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Flag-based codes with gt flags; channel 1 not write-ready so NCW is true
        cmp_a = 16'd9; cmp_b = 16'd4; cmp_we = 1'b1;
        tick();
        cmp_we = 1'b0; wait_mode = 1'b0; accel_sel = 1'b1; can_write = 2'b01;
        for (int i = 0; i < 6; i++) begin
            cond = 4'(codes[i]); req = 1'b1;
            tick();
            check($sformatf("code%0d", codes[i]), 32'({done, taken}), 32'({1'b1, 1'(exps[i])}));
        end
        req = 1'b0;
        tick();

        // Out-of-range select on the three-channel instance reads as not ready
        sel3 = 2'd3; can_read3 = 3'b111; can_write3 = 3'b111;
        cond = 4'd8; req = 1'b1;
        tick();
        check("oor_ncr", 32'({done3, taken3}), 32'b11);
        cond = 4'd7;
        tick();
        check("oor_cw", 32'({done3, taken3}), 32'b10);
        cond = 4'd12;
        tick();
        check("oor_c12", 32'({done3, taken3}), 32'b10);
        sel3 = 2'd2; can_read3 = 3'b100; cond = 4'd6;
        tick();
        check("inrange_cr", 32'({done3, taken3}), 32'b11);
        req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
